// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the RX pin, the 8N1 receiver and its consumer.
`timescale 1ns/1ps
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data_i;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport slave (input rxd, output data_i, rx_valid, frame_err, busy);
    modport master(output rxd, input data_i, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, stop-bit check,
// held output byte with one-cycle valid / framing-error strobes.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;
    logic          meta_reg, sync_reg;
    logic          rxd_s;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= rx.rxd;
            sync_reg <= meta_reg;
        end
    end

    assign rxd_s = sync_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shreg_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shreg_reg   <= shreg_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shreg_next   = shreg_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next   = S_START;
                    clk_cnt_next = '0;
                end
            end
            S_START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    // A start bit that is gone by mid-bit was line noise.
                    if (!rxd_s) begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shreg_next   = {rxd_s, shreg_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                    if (rxd_s) begin
                        data_next  = shreg_reg;
                        valid_next = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rx.data_i    = data_reg;
    assign rx.rx_valid  = valid_reg;
    assign rx.frame_err = ferr_reg;
    assign rx.busy      = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are scheduled in absolute
// time, expected outcomes queued at send time and matched by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB    = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    int         checks;
    int         passed;
    exp_t       exp_q[$];
    logic [7:0] last_good;

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            passed++;
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (bus.rx_valid || bus.frame_err)) begin
                if (bus.rx_valid && bus.frame_err) begin
                    check("valid_and_err_together", 1, 0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {bus.frame_err, bus.rx_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", bus.frame_err, e.err);
                    check("data_i", bus.data_i, e.data);
                    $display("rx %s data=%02h expected=%02h", bus.frame_err ? "frame_err" : "byte",
                             bus.data_i, e.data);
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame starting now; edges are placed at absolute times so that
    // jitter does not accumulate while a constant bit_ns models rate skew.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bit_ns,
                              input bit jitter);
        logic [9:0] bits;
        time        t0;
        time        target;
        int         j;
        bits = {stop_ok, b, 1'b0};
        if (stop_ok) begin
            exp_q.push_back('{err: 1'b0, data: b});
            last_good = b;
        end else begin
            exp_q.push_back('{err: 1'b1, data: last_good});
        end
        t0 = $time;
        for (int i = 0; i < 10; i++) begin
            j = (jitter && i > 0) ? (2 * int'($urandom_range(0, 8)) - 8) : 0;
            target = t0 + time'(i * bit_ns + j);
            if (target > $time) #(target - $time);
            bus.rxd = bits[i];
        end
        target = t0 + time'(10 * bit_ns);
        if (target > $time) #(target - $time);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.busy, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rxd = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_good = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;
        checks    = 0;
        passed    = 0;
        last_good = 8'h00;
        rst       = 1'b0;
        bus.rxd   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_i", bus.data_i, 8'h00);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_busy", bus.busy, 0);
        align();
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Clean frame.
        align();
        send_frame(8'hA5, 1'b1, BIT_NS, 1'b0);
        wait_idle("idle_after_a5", 40);
        check("held_a5", bus.data_i, 8'hA5);

        // Short glitch must be rejected at the start-bit check.
        repeat (10) @(posedge clk);
        align();
        bus.rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rxd = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", bus.busy, 1);
        wait_idle("glitch_idle_in_12", 12);
        check("glitch_data_kept", bus.data_i, 8'hA5);

        // Bad stop bit followed by a held-low line, then a good frame.
        repeat (10) @(posedge clk);
        align();
        send_frame(8'h3C, 1'b0, BIT_NS, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_busy_held", bus.busy, 1);
        check("break_data_kept", bus.data_i, 8'hA5);
        align();
        bus.rxd = 1'b1;
        wait_idle("break_exit", 8);
        repeat (5) @(posedge clk);
        align();
        send_frame(8'h5A, 1'b1, BIT_NS, 1'b0);
        wait_idle("idle_after_5a", 40);
        check("held_5a", bus.data_i, 8'h5A);

        // Back-to-back frames with no idle gap.
        repeat (7) @(posedge clk);
        align();
        send_frame(8'h00, 1'b1, BIT_NS, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_NS, 1'b0);
        wait_idle("idle_after_b2b", 40);
        check("held_ff", bus.data_i, 8'hFF);

        // Reset during data bit 3 abandons the frame silently.
        repeat (9) @(posedge clk);
        align();
        bus.rxd = 1'b0;
        #(BIT_NS);
        bus.rxd = 1'b1;
        #(BIT_NS);
        bus.rxd = 1'b0;
        #(BIT_NS);
        bus.rxd = 1'b0;
        #(BIT_NS);
        bus.rxd = 1'b0;
        #(BIT_NS / 2);
        pulse_reset();
        @(negedge clk);
        check("after_reset_data_i", bus.data_i, 8'h00);
        check("after_reset_busy", bus.busy, 0);
        repeat (2 * CPB) @(posedge clk);
        check("abort_no_pending", exp_q.size(), 0);
        align();
        send_frame(8'h81, 1'b1, BIT_NS, 1'b0);
        wait_idle("idle_after_81", 40);

        // Slow sender (+5% bit period) and edge jitter.
        repeat (6) @(posedge clk);
        align();
        send_frame(8'h55, 1'b1, BIT_NS + BIT_NS / 20 + 1, 1'b0);
        wait_idle("idle_after_skew", 40);
        check("held_55", bus.data_i, 8'h55);
        align();
        send_frame(8'hC3, 1'b1, BIT_NS, 1'b1);
        wait_idle("idle_after_jitter", 40);

        // Randomized traffic.
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 30);
            repeat (gap) @(posedge clk);
            align();
            send_frame(b, ok, BIT_NS, 1'($urandom_range(0, 1)));
            if (!ok) begin
                repeat ($urandom_range(0, 30)) @(posedge clk);
                align();
                bus.rxd = 1'b1;
            end
            wait_idle("idle_random", 40);
        end

        repeat (5) @(posedge clk);
        check("all_expected_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
